// File: rtl/user_id_pkg.sv
`default_nettype none
// ============================================================================
// Module : user_id_pkg
// Purpose: Shared types and constants for the user project ID reader.
//          Holds the capture and serial state encodings, the ID word width
//          and the read-port address of the status word.
// Rev    : 1.0 - initial release
// ============================================================================
package user_id_pkg;

  localparam int   ID_WIDTH    = 32;
  localparam logic STATUS_ADDR = 1'b1;

  // Capture sequencer: settle, sample twice, lock.
  typedef enum logic [1:0] {
    CAP_WAIT     = 2'd0,
    CAP_SAMPLE_A = 2'd1,
    CAP_SAMPLE_B = 2'd2,
    CAP_LOCKED   = 2'd3
  } cap_state_t;

  // Serial readout sequencer.
  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_SHIFT = 2'd1,
    SER_TAIL  = 2'd2
  } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/user_id_shifter.sv
`default_nettype none
// ============================================================================
// Module : user_id_shifter
// Purpose: Shifts a 32-bit word off-chip MSB first. The receiver samples on
//          rising ser_clk; data changes only after falling ser_clk. The frame
//          stays high for 64 half-periods of shifting plus one trailing
//          half-period with ser_clk low.
// Ports  : clk, rst_n        - system clock, async active-low reset
//          load              - accept word and start a transfer (IDLE only)
//          word[31:0]        - word to send
//          ser_clk/ser_data  - serial clock and data
//          ser_frame         - high for the whole transfer
//          busy              - transfer in progress
// Rev    : 1.0 - initial release
// ============================================================================
module user_id_shifter
  import user_id_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [ID_WIDTH-1:0] word,
  output logic                ser_clk,
  output logic                ser_data,
  output logic                ser_frame,
  output logic                busy
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  ser_state_t          state;
  logic [7:0]          div_cnt;
  logic [4:0]          fall_cnt;
  logic [ID_WIDTH-1:0] shreg;
  logic                half_done;

  assign half_done = (div_cnt == DIV_LAST);
  assign busy      = (state != SER_IDLE);
  // Data is taken straight from the shift register MSB; clearing the
  // register at the end of a transfer returns ser_data to 0.
  assign ser_data  = shreg[ID_WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SER_IDLE;
      div_cnt   <= 8'd0;
      fall_cnt  <= 5'd0;
      shreg     <= '0;
      ser_clk   <= 1'b0;
      ser_frame <= 1'b0;
    end else begin
      case (state)
        SER_IDLE: begin
          if (load) begin
            shreg     <= word;
            ser_frame <= 1'b1;
            ser_clk   <= 1'b0;
            div_cnt   <= 8'd0;
            fall_cnt  <= 5'd0;
            state     <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (half_done) begin
            div_cnt <= 8'd0;
            ser_clk <= ~ser_clk;
            if (ser_clk) begin
              // Falling edge: either the 32nd (move to the tail) or
              // advance to the next bit.
              if (fall_cnt == 5'd31) begin
                state <= SER_TAIL;
              end else begin
                fall_cnt <= fall_cnt + 5'd1;
                shreg    <= {shreg[ID_WIDTH-2:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SER_TAIL: begin
          if (half_done) begin
            div_cnt   <= 8'd0;
            ser_frame <= 1'b0;
            shreg     <= '0;
            state     <= SER_IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/user_id_reader.sv
`default_nettype none
// ============================================================================
// Module : user_id_reader
// Purpose: Captures the tie-cell mask_rev word after reset (two matching
//          samples required), flags a mismatch against EXPECTED_ID, serves
//          the word and a status word on a single-cycle read port, and can
//          shift the word out serially.
// Ports  : wb_clk_i, wb_rstn_i    - clock, async active-low reset
//          mask_rev[31:0]         - static ID word
//          rd_req, rd_addr        - read strobe / address (0 ID, 1 status)
//          rd_ack, rd_data[31:0]  - read response one cycle after rd_req
//          ser_start              - request a serial transfer
//          ser_clk/data/frame     - serial interface
//          id_valid, id_mismatch  - capture status
// Rev    : 1.0 - initial release
// ============================================================================
module user_id_reader
  import user_id_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID   = 32'h0,
  parameter int          CLK_DIV       = 4,
  parameter int          SETTLE_CYCLES = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rstn_i,
  input  logic [ID_WIDTH-1:0] mask_rev,
  input  logic                rd_req,
  input  logic                rd_addr,
  output logic                rd_ack,
  output logic [ID_WIDTH-1:0] rd_data,
  input  logic                ser_start,
  output logic                ser_clk,
  output logic                ser_data,
  output logic                ser_frame,
  output logic                id_valid,
  output logic                id_mismatch
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  cap_state_t          cap_state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [ID_WIDTH-1:0] tmp;
  logic [ID_WIDTH-1:0] id_reg;
  logic                ser_busy;
  logic                ser_load;
  logic [ID_WIDTH-1:0] status_word;
  logic [ID_WIDTH-1:0] id_word;

  // ---------------------------------------------------------------- capture
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      cap_state   <= CAP_WAIT;
      settle_cnt  <= '0;
      tmp         <= '0;
      id_reg      <= '0;
      id_valid    <= 1'b0;
      id_mismatch <= 1'b0;
    end else begin
      case (cap_state)
        CAP_WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            cap_state  <= CAP_SAMPLE_A;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CAP_SAMPLE_A: begin
          tmp       <= mask_rev;
          cap_state <= CAP_SAMPLE_B;
        end
        CAP_SAMPLE_B: begin
          // Two consecutive identical samples are required before the
          // tie-cell outputs are trusted; otherwise settle again.
          if (mask_rev == tmp) begin
            id_reg      <= tmp;
            id_mismatch <= (tmp != EXPECTED_ID);
            cap_state   <= CAP_LOCKED;
          end else begin
            settle_cnt <= '0;
            cap_state  <= CAP_WAIT;
          end
        end
        CAP_LOCKED: begin
          // id_valid follows one cycle after lock, so a ser_start coinciding
          // with the lock transition is still refused.
          id_valid <= 1'b1;
        end
        default: cap_state <= CAP_WAIT;
      endcase
    end
  end

  // -------------------------------------------------------------- read port
  assign status_word = {{(ID_WIDTH-3){1'b0}}, ser_busy, id_mismatch, id_valid};
  assign id_word     = id_valid ? id_reg : '0;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) begin
        rd_data <= (rd_addr == STATUS_ADDR) ? status_word : id_word;
      end
    end
  end

  // ----------------------------------------------------------------- serial
  assign ser_load = ser_start & id_valid & ~ser_busy;

  user_id_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (wb_clk_i),
    .rst_n     (wb_rstn_i),
    .load      (ser_load),
    .word      (id_reg),
    .ser_clk   (ser_clk),
    .ser_data  (ser_data),
    .ser_frame (ser_frame),
    .busy      (ser_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_user_id_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_user_id_reader
// Purpose: Directed bench for user_id_reader with scoreboard queues for
//          read responses and serial frames.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_user_id_reader;

  localparam logic [31:0] EXP_ID = 32'hA5C3_0F19;
  localparam int          DIV    = 2;
  localparam int          SETTLE = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mask_rev = 32'h0;
  logic        rd_req = 1'b0;
  logic        rd_addr = 1'b0;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        ser_start = 1'b0;
  logic        ser_clk, ser_data, ser_frame;
  logic        id_valid, id_mismatch;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd_exp[$];
  logic [31:0] ser_exp[$];

  user_id_reader #(
    .EXPECTED_ID   (EXP_ID),
    .CLK_DIV       (DIV),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rst_n),
    .mask_rev    (mask_rev),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .ser_start   (ser_start),
    .ser_clk     (ser_clk),
    .ser_data    (ser_data),
    .ser_frame   (ser_frame),
    .id_valid    (id_valid),
    .id_mismatch (id_mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not seen within bound", name);
  endtask

  // ------------------------------------------------------- read monitor
  logic req_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= 1'b0;
    else        req_q <= rd_req;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_ack || req_q) check("rd_ack_timing", {31'b0, rd_ack}, {31'b0, req_q});
      if (rd_ack) begin
        if (rd_exp.size() == 0) flag("rd_unexpected_ack");
        else check("rd_data", rd_data, rd_exp.pop_front());
      end
    end
  end

  // ----------------------------------------------------- serial monitor
  logic [31:0] bits = 32'h0;
  int          nbits = 0;
  // Frame rise always happens with ser_clk low, so it clears the collector;
  // a rising ser_clk shifts in the sampled bit.
  always @(posedge ser_frame or posedge ser_clk) begin
    if (ser_clk) begin
      bits  = {bits[30:0], ser_data};
      nbits = nbits + 1;
    end else begin
      bits  = 32'h0;
      nbits = 0;
    end
  end

  logic frame_prev = 1'b0;
  int   frame_len = 0;
  always @(negedge clk) begin
    if (ser_frame && !frame_prev) frame_len = 1;
    else if (ser_frame)           frame_len = frame_len + 1;
    if (!ser_frame && frame_prev) begin
      if (!rst_n) begin
        // Aborted by reset: drop its expectation.
        if (ser_exp.size() != 0) void'(ser_exp.pop_front());
      end else if (ser_exp.size() == 0) begin
        flag("ser_unexpected_frame");
      end else begin
        check("ser_word", bits, ser_exp.pop_front());
        check("ser_bit_count", nbits, 32);
        check("ser_frame_len", frame_len, 65 * DIV);
      end
    end
    frame_prev = ser_frame;
  end

  // ---------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic addr, input logic [31:0] exp);
    rd_req  = 1'b1;
    rd_addr = addr;
    rd_exp.push_back(exp);
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic apply_reset(input logic [31:0] mask);
    rst_n     = 1'b0;
    mask_rev  = mask;
    rd_req    = 1'b0;
    ser_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!id_valid && n < 100) begin
      tick();
      n++;
    end
    if (!id_valid) flag("id_valid_timeout");
  endtask

  task automatic start_ser(input logic [31:0] exp);
    ser_start = 1'b1;
    ser_exp.push_back(exp);
    tick();
    ser_start = 1'b0;
  endtask

  task automatic wait_ser_done();
    int n = 0;
    while (ser_exp.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (ser_exp.size() != 0) flag("ser_done_timeout");
  endtask

  initial begin
    int n;

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_ack", {31'b0, rd_ack}, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_ser_clk", {31'b0, ser_clk}, 32'h0);
    check("rst_ser_data", {31'b0, ser_data}, 32'h0);
    check("rst_ser_frame", {31'b0, ser_frame}, 32'h0);
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_id_mismatch", {31'b0, id_mismatch}, 32'h0);

    // Matching ID: lock latency, status and ID reads back-to-back.
    apply_reset(EXP_ID);
    wait_valid(n);
    check("lock_latency", n, SETTLE + 3);
    check("match_mismatch_flag", {31'b0, id_mismatch}, 32'h0);
    rd(1'b1, 32'h1);
    rd(1'b0, EXP_ID);
    tick();

    // Unstable word between the two samples, then a mismatching ID.
    apply_reset(32'h1234_5678);
    repeat (SETTLE + 1) tick();
    mask_rev = 32'h0000_0001;
    rd(1'b0, 32'h0);
    rd(1'b1, 32'h0);
    ser_start = 1'b1;
    tick();
    ser_start = 1'b0;
    tick();
    check("frame_before_valid", {31'b0, ser_frame}, 32'h0);
    wait_valid(n);
    check("relock_latency", SETTLE + 5 + n, 2 * SETTLE + 5);
    check("mismatch_flag", {31'b0, id_mismatch}, 32'h1);
    rd(1'b1, 32'h3);
    rd(1'b0, 32'h0000_0001);
    tick();

    // Full serial transfer with a restart attempt while busy.
    apply_reset(32'h8000_0001);
    wait_valid(n);
    start_ser(32'h8000_0001);
    repeat (20) tick();
    ser_start = 1'b1;
    tick();
    ser_start = 1'b0;
    rd(1'b1, 32'h7);
    wait_ser_done();
    check("frame_low_after", {31'b0, ser_frame}, 32'h0);
    rd(1'b1, 32'h3);
    tick();

    // Asynchronous reset at bit 10 of a transfer.
    apply_reset(32'h8000_0001);
    wait_valid(n);
    start_ser(32'h8000_0001);
    n = 0;
    while (nbits < 10 && n < 200) begin
      tick();
      n++;
    end
    if (nbits < 10) flag("bit10_timeout");
    rd_req  = 1'b1;
    rd_addr = 1'b0;
    tick();
    rd_req  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("abort_ser_clk", {31'b0, ser_clk}, 32'h0);
    check("abort_ser_data", {31'b0, ser_data}, 32'h0);
    check("abort_ser_frame", {31'b0, ser_frame}, 32'h0);
    check("abort_id_valid", {31'b0, id_valid}, 32'h0);
    check("abort_rd_ack", {31'b0, rd_ack}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_valid(n);
    check("recapture_latency", n, SETTLE + 3);
    start_ser(32'h8000_0001);
    wait_ser_done();
    tick();
    tick();

    check("rd_queue_drained", rd_exp.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/user_id_reader.md
Name: user_id_reader

Overview:
- Reader side of the user project ID programmed into the tie-cell array.
- Captures the 32-bit mask_rev word after reset and checks it against an expected value.
- Serves the word to the housekeeping logic through a single-cycle register read port.
- Can also shift the word off-chip serially on request, for tester and board-level readout of the chip ID.

Parameters:
- EXPECTED_ID, 32'h0: ID value the design expects; a captured value that differs sets id_mismatch.
- CLK_DIV, 4: system clocks per ser_clk half-period. Legal range 1..255.
- SETTLE_CYCLES, 8: clocks to wait after reset release before the first capture sample. Minimum 1.

Ports:
- wb_clk_i  input  1  system clock.
- wb_rstn_i  input  1  asynchronous active-low reset.
- mask_rev  input  32  static ID word from the tie-cell array.
- rd_req  input  1  read strobe, one cycle.
- rd_addr  input  1  0 = ID word, 1 = status word.
- rd_ack  output  1  read acknowledge.
- rd_data  output  32  read data.
- ser_start  input  1  pulse that starts a serial transfer.
- ser_clk  output  1  serial clock.
- ser_data  output  1  serial data.
- ser_frame  output  1  high for the whole serial transfer.
- id_valid  output  1  captured ID is stable.
- id_mismatch  output  1  captured ID differs from EXPECTED_ID.

Behaviour:
- Reset is asynchronous active-low. All flops clear. Output reset values:
  - rd_ack = 0, rd_data = 0.
  - ser_clk = 0, ser_data = 0, ser_frame = 0.
  - id_valid = 0, id_mismatch = 0.
  - Internal id_reg = 0.
- Capture FSM, states WAIT, SAMPLE_A, SAMPLE_B, LOCKED:
  - WAIT: count SETTLE_CYCLES clocks, then go to SAMPLE_A.
  - SAMPLE_A: latch mask_rev into tmp, go to SAMPLE_B.
  - SAMPLE_B: compare mask_rev with tmp.
    - Equal: id_reg <= tmp, go to LOCKED. id_valid rises in the cycle after SAMPLE_B.
    - Not equal: go back to WAIT and restart the counter.
  - LOCKED: terminal until reset. id_mismatch = (id_reg != EXPECTED_ID), registered, updated on entry to LOCKED.
- Read port:
  - rd_req seen in cycle N gives rd_ack = 1 and valid rd_data in cycle N+1, for one cycle only.
  - rd_addr = 0 returns id_reg, which reads 0 until id_valid.
  - rd_addr = 1 returns {29'b0, ser_busy, id_mismatch, id_valid}.
  - Back-to-back requests each get their own ack one cycle later.
  - rd_data holds its last value when rd_ack is low.
- Serial FSM, states IDLE, SHIFT, TAIL:
  - IDLE: ser_start is ignored unless id_valid. When accepted: copy id_reg into the shift register, bit count = 32, ser_frame = 1 on the next edge, ser_data = bit 31.
  - SHIFT:
    - Divider counts CLK_DIV clocks per half-period.
    - ser_clk toggles at each half-period boundary.
    - Data changes only after a falling ser_clk edge. The receiver samples on the rising edge. Order is MSB first.
    - After the 32nd falling edge, go to TAIL.
  - TAIL: hold ser_frame high for one more half-period with ser_clk low, then ser_frame = 0, ser_data = 0, return to IDLE.
  - Transfer length: frame high for exactly 65 half-periods (32 full ser_clk periods plus the TAIL half-period) = 65*CLK_DIV clocks, plus 1 clock of start latency.
  - ser_busy = (state != IDLE).
  - ser_start while busy is ignored; no queueing.
  - ser_start in the same cycle as the SAMPLE_B → LOCKED transition is ignored, because id_valid is not yet high.
- Reset mid-transfer: all outputs go low immediately, asynchronously. After reset release the capture sequence re-runs.
- The block never reads mask_rev after LOCKED.

Decomposition:
- Package user_id_pkg holds:
  - capture state enum (WAIT, SAMPLE_A, SAMPLE_B, LOCKED);
  - serial state enum (IDLE, SHIFT, TAIL);
  - constants ID_WIDTH = 32 and STATUS_ADDR = 1'b1.
- One sub-module, user_id_shifter: the serial FSM plus divider. Inputs are a load strobe and a 32-bit word; outputs are ser_clk, ser_data, ser_frame and busy.
- The top level holds the capture FSM and the read port.

Test Plan:
- Reset, stable mask_rev = 32'hA5C3_0F19, EXPECTED_ID = 32'hA5C3_0F19:
  → id_valid rises SETTLE_CYCLES + 3 clocks after release, id_mismatch = 0.
  → status read returns 32'h1, ID read returns 32'hA5C3_0F19 with rd_ack exactly one cycle after rd_req.
- mask_rev = 32'h0000_0001 with EXPECTED_ID = 0:
  → id_mismatch = 1, status read = 32'h3.
- mask_rev changes between SAMPLE_A and SAMPLE_B:
  → no lock; capture retries; locks on the next stable pair.
  → ID read before lock returns 0.
- CLK_DIV = 2, ser_start after lock with ID 32'h8000_0001:
  → bits sampled on rising ser_clk are 1, 30 zeros, 1.
  → ser_frame high for 130 clocks.
  → ser_start mid-transfer has no effect; ser_busy reads 1.
- ser_start before id_valid:
  → ignored; ser_frame stays 0.
- wb_rstn_i asserted at bit 10 of a transfer:
  → ser_clk, ser_data, ser_frame, id_valid and rd_ack go 0 without waiting for a clock edge.
  → after release the block re-captures and a new transfer sends all 32 bits.
